// File: rtl/hls_module_status_monitor.sv
// rtl/hls_module_status_monitor.sv - per-channel ap_ctrl handshake monitor with frozen statistics read port
module hls_module_status_monitor #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int LAT_W  = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_finish,
    input  logic              i_clear,
    input  logic [NUM_CH-1:0] i_ap_start,
    input  logic [NUM_CH-1:0] i_ap_ready,
    input  logic [NUM_CH-1:0] i_ap_done,
    input  logic [NUM_CH-1:0] i_ap_continue,
    input  logic              i_rd_en,
    input  logic [3:0]        i_rd_ch,
    input  logic [2:0]        i_rd_sel,
    output logic              o_rd_valid,
    output logic [CNT_W-1:0]  o_rd_data,
    output logic              o_frozen,
    output logic [NUM_CH-1:0] o_stalled,
    output logic [NUM_CH-1:0] o_sat
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_STALL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    state_t           r_state     [NUM_CH];
    state_t           w_state_nxt [NUM_CH];
    logic [CNT_W-1:0] r_ready_cnt [NUM_CH];
    logic [CNT_W-1:0] w_ready_nxt [NUM_CH];
    logic [CNT_W-1:0] r_done_cnt  [NUM_CH];
    logic [CNT_W-1:0] w_done_nxt  [NUM_CH];
    logic [CNT_W-1:0] r_stall_cnt [NUM_CH];
    logic [CNT_W-1:0] w_stall_nxt [NUM_CH];
    logic [CNT_W-1:0] r_busy_cnt  [NUM_CH];
    logic [CNT_W-1:0] w_busy_nxt  [NUM_CH];
    logic [LAT_W-1:0] r_cur_lat   [NUM_CH];
    logic [LAT_W-1:0] w_cur_lat_nxt [NUM_CH];
    logic [LAT_W-1:0] w_lat_step  [NUM_CH];
    logic [LAT_W-1:0] r_max_lat   [NUM_CH];
    logic [LAT_W-1:0] w_max_lat_nxt [NUM_CH];
    logic [NUM_CH-1:0] r_sat;
    logic [NUM_CH-1:0] w_sat_nxt;
    logic              r_frozen;
    logic [CNT_W-1:0]  w_rd_mux;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] v);
        return (v == LAT_MAX) ? v : v + LAT_W'(1);
    endfunction

    function automatic logic [LAT_W-1:0] lat_max(input logic [LAT_W-1:0] a, input logic [LAT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // In DONE_STALL, r_cur_lat already holds the final latency latched at ap_done.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_state_nxt[c]   = r_state[c];
            w_ready_nxt[c]   = r_ready_cnt[c];
            w_done_nxt[c]    = r_done_cnt[c];
            w_stall_nxt[c]   = r_stall_cnt[c];
            w_busy_nxt[c]    = r_busy_cnt[c];
            w_cur_lat_nxt[c] = r_cur_lat[c];
            w_max_lat_nxt[c] = r_max_lat[c];
            w_lat_step[c]    = lat_inc(r_cur_lat[c]);

            if (i_ap_start[c] && i_ap_ready[c])
                w_ready_nxt[c] = cnt_inc(r_ready_cnt[c]);
            if (r_state[c] != S_IDLE)
                w_busy_nxt[c] = cnt_inc(r_busy_cnt[c]);

            case (r_state[c])
                S_IDLE: begin
                    if (i_ap_start[c]) begin
                        if (i_ap_done[c] && i_ap_continue[c]) begin
                            w_done_nxt[c]    = cnt_inc(r_done_cnt[c]);
                            w_max_lat_nxt[c] = lat_max(r_max_lat[c], LAT_W'(1));
                        end else begin
                            w_state_nxt[c]   = S_ACTIVE;
                            w_cur_lat_nxt[c] = LAT_W'(1);
                        end
                    end
                end
                S_ACTIVE: begin
                    w_cur_lat_nxt[c] = w_lat_step[c];
                    if (i_ap_done[c]) begin
                        if (i_ap_continue[c]) begin
                            w_state_nxt[c]   = S_IDLE;
                            w_done_nxt[c]    = cnt_inc(r_done_cnt[c]);
                            w_max_lat_nxt[c] = lat_max(r_max_lat[c], w_lat_step[c]);
                        end else begin
                            w_state_nxt[c] = S_STALL;
                            w_stall_nxt[c] = cnt_inc(r_stall_cnt[c]);
                        end
                    end
                end
                S_STALL: begin
                    if (i_ap_continue[c]) begin
                        w_state_nxt[c]   = S_IDLE;
                        w_done_nxt[c]    = cnt_inc(r_done_cnt[c]);
                        w_max_lat_nxt[c] = lat_max(r_max_lat[c], r_cur_lat[c]);
                    end else begin
                        w_stall_nxt[c] = cnt_inc(r_stall_cnt[c]);
                    end
                end
                default: w_state_nxt[c] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_sat_nxt = r_sat;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ready_nxt[c] == CNT_MAX || w_done_nxt[c] == CNT_MAX ||
                w_stall_nxt[c] == CNT_MAX || w_busy_nxt[c] == CNT_MAX)
                w_sat_nxt[c] = 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c]     <= S_IDLE;
                r_ready_cnt[c] <= '0;
                r_done_cnt[c]  <= '0;
                r_stall_cnt[c] <= '0;
                r_busy_cnt[c]  <= '0;
                r_cur_lat[c]   <= '0;
                r_max_lat[c]   <= '0;
            end
            r_sat    <= '0;
            r_frozen <= 1'b0;
        end else if (i_clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c]     <= S_IDLE;
                r_ready_cnt[c] <= '0;
                r_done_cnt[c]  <= '0;
                r_stall_cnt[c] <= '0;
                r_busy_cnt[c]  <= '0;
                r_cur_lat[c]   <= '0;
                r_max_lat[c]   <= '0;
            end
            r_sat    <= '0;
            r_frozen <= 1'b0;
        end else begin
            if (!r_frozen) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_state[c]     <= w_state_nxt[c];
                    r_ready_cnt[c] <= w_ready_nxt[c];
                    r_done_cnt[c]  <= w_done_nxt[c];
                    r_stall_cnt[c] <= w_stall_nxt[c];
                    r_busy_cnt[c]  <= w_busy_nxt[c];
                    r_cur_lat[c]   <= w_cur_lat_nxt[c];
                    r_max_lat[c]   <= w_max_lat_nxt[c];
                end
                r_sat <= w_sat_nxt;
            end
            if (i_finish)
                r_frozen <= 1'b1;
        end
    end

    // Channel indices beyond NUM_CH match no loop iteration and read as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_rd_ch == 4'(c)) begin
                case (i_rd_sel)
                    3'd0:    w_rd_mux = r_ready_cnt[c];
                    3'd1:    w_rd_mux = r_done_cnt[c];
                    3'd2:    w_rd_mux = r_stall_cnt[c];
                    3'd3:    w_rd_mux = r_busy_cnt[c];
                    3'd4:    w_rd_mux = CNT_W'(r_max_lat[c]);
                    3'd5:    w_rd_mux = CNT_W'(r_state[c]);
                    default: w_rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= i_rd_en;
            o_rd_data  <= i_rd_en ? w_rd_mux : '0;
        end
    end

    always_comb begin
        o_stalled = '0;
        for (int c = 0; c < NUM_CH; c++)
            o_stalled[c] = (r_state[c] == S_STALL);
    end

    assign o_sat    = r_sat;
    assign o_frozen = r_frozen;

endmodule

// File: doc/hls_module_status_monitor.md
Name: hls_module_status_monitor

Overview:
- Synthesisable, multi-channel successor to the per-module ap_ctrl status monitors.
- Observes the ap_start, ap_ready, ap_done and ap_continue handshakes of NUM_CH HLS module instances.
- Per channel, tracks a transaction FSM, event counters, busy and stall cycles, and the worst-case start-to-done latency.
- When the top-level finish signal is seen, it freezes all statistics. The bench or a debug host then reads them back through a registered read port.

Parameters:
- NUM_CH, 2, number of monitored module channels (1..16).
- CNT_W, 32, width of every event and cycle counter.
- LAT_W, 16, width of the latency tracker and max-latency register.

Ports:
- clock, input, 1, single design clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-high reset.
- finish, input, 1, end-of-simulation/run indication.
- clear, input, 1, synchronous statistics clear.
- ap_start, input, NUM_CH, per-channel ap_start.
- ap_ready, input, NUM_CH, per-channel ap_ready.
- ap_done, input, NUM_CH, per-channel ap_done.
- ap_continue, input, NUM_CH, per-channel ap_continue; tie high for channels without it.
- rd_en, input, 1, read request.
- rd_ch, input, 4, channel index to read.
- rd_sel, input, 3, statistic selector.
- rd_valid, output, 1, read data valid.
- rd_data, output, CNT_W, read data.
- frozen, output, 1, statistics frozen after finish.
- stalled, output, NUM_CH, channel is currently in DONE_STALL.
- sat, output, NUM_CH, sticky flag: some counter of the channel saturated.

Behaviour:
- Reset (async, reset=1):
  - All counters, max_lat and cur_lat go to 0.
  - All FSMs go to IDLE.
  - frozen=0, rd_valid=0, rd_data=0, stalled=0, sat=0.
- Priority per cycle: clear > frozen hold > normal update.
- clear=1:
  - Same values as reset, except the read port still completes normally.
  - Applies even when frozen; it deasserts frozen.
- Freeze:
  - finish=1 sampled at an edge sets frozen=1 from the next cycle. frozen is sticky until reset or clear.
  - Events in the finish cycle itself are still counted.
  - While frozen, FSMs and counters hold and stalled holds.
- Per-channel FSM states: IDLE, ACTIVE, DONE_STALL (encoded 0, 1, 2).
  - IDLE with ap_start=1: enter ACTIVE, cur_lat=1.
    - Exception: if ap_done=1 and ap_continue=1 in the same cycle, the transaction completes with latency 1. done_cnt+1, max_lat=max(max_lat,1), and the FSM stays IDLE.
  - ACTIVE: cur_lat increments each cycle, saturating at 2^LAT_W-1.
    - ap_done=1 and ap_continue=1: go to IDLE, done_cnt+1, max_lat=max(max_lat,cur_lat+1).
    - ap_done=1 and ap_continue=0: go to DONE_STALL, stall_cnt+1, and latch final latency cur_lat+1.
    - ap_start in ACTIVE does not affect the FSM (pipelined restarts are visible only in ready_cnt).
  - DONE_STALL: while ap_continue=0, stall_cnt+1 each cycle. When ap_continue=1: go to IDLE, done_cnt+1, max_lat updated with the latched latency.
  - Latency excludes stall cycles.
- Counters, independent of FSM state:
  - ready_cnt +1 on each cycle with ap_start=1 and ap_ready=1.
  - busy_cnt +1 on each cycle the FSM is in ACTIVE or DONE_STALL.
- Saturation: every counter stops at all-ones; reaching it sets sat[ch] (sticky).
- stalled[ch] is 1 iff the channel's FSM is in DONE_STALL (registered state, no combinational input path).
- Read port:
  - rd_en=1 in cycle N gives rd_valid=1 and rd_data in cycle N+1 (one-cycle latency).
  - rd_valid=0 in every cycle after a cycle with rd_en=0.
  - Back-to-back reads are allowed, one per cycle.
  - rd_sel map: 0 ready_cnt, 1 done_cnt, 2 stall_cnt, 3 busy_cnt, 4 max_lat (zero-extended), 5 FSM state (zero-extended), 6 and 7 return 0.
  - rd_ch >= NUM_CH returns 0 with rd_valid=1.
  - Reads reflect register values before the update of cycle N.
- Reset mid-transaction discards the in-flight latency; no partial count is recorded.

Test Plan:
- Ch0: start at cycle 5, ap_ready at 5, done+continue at cycle 9 -> read sel1=1, sel0=1, sel4=5, sel3=4, sel2=0; stalled[0] never 1.
- Ch1: start at 3, done at 6 with continue=0 for 4 cycles, then continue=1 -> stalled[1]=1 for 4 cycles, sel2=4, sel4=4, sel3=7, sel5 reads 0 after completion.
- Same-cycle start+done+continue on ch0 three times -> done_cnt=3, max_lat=1, busy_cnt=0.
- finish pulse at cycle 20, then further starts/dones -> frozen=1 from cycle 21, counters unchanged. clear then zeroes all reads and frozen=0.
- Parameterisation: CNT_W=4, hold ap_start=ap_ready=1 for 20 cycles -> ready_cnt reads 15, sat[ch]=1.
- rd_ch=5 with NUM_CH=2 -> rd_data=0, rd_valid=1. Async reset asserted mid-ACTIVE -> immediate zero outputs; FSM in IDLE after release.
